// File: rtl/seq_blink_pkg.sv
// seq_blink_pkg: shared types and defaults for the
// sequential blinker and its receive-side monitor.
package seq_blink_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEAS
  } blink_mon_st_e;

  localparam int BLINK_NUM_CH = 5;

  localparam int BLINK_EXP [BLINK_NUM_CH] =
    '{50, 25, 17, 10, 5};

  // Picks the expected half-period of channel c.
  function automatic int exp_sel(
    input int c,
    input int e0,
    input int e1,
    input int e2,
    input int e3,
    input int e4
  );
    case (c)
      0:       return e0;
      1:       return e1;
      2:       return e2;
      3:       return e3;
      default: return e4;
    endcase
  endfunction

endpackage

// File: rtl/seq_blink_monitor_ch.sv
// blink_period_ch: one monitored blink line.
// Sync, edge detect, half-period counter, FSM, compare.
module blink_period_ch
  import seq_blink_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int EXP    = 50,
  parameter int TOL    = 1,
  parameter int LOCK_N = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_blink,
  input  logic             i_clr,
  output logic             o_meas_valid,
  output logic [CNT_W-1:0] o_period,
  output logic             o_lock,
  output logic             o_err,
  output logic             o_stuck
);

  localparam int PW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W:0] EXP_V =
    (CNT_W + 1)'(EXP);
  localparam logic [CNT_W:0] TOL_V =
    (CNT_W + 1)'(TOL);
  localparam logic [CNT_W+1:0] STK_V =
    (CNT_W + 2)'(2 * EXP + TOL);
  localparam logic [PW-1:0] LOCK_V = PW'(LOCK_N);

  if (EXP >= 2 ** (CNT_W - 1) ||
      TOL >= 2 ** (CNT_W - 1) ||
      EXP < 1 || LOCK_N < 1) begin : g_bad_par
    $error("blink_period_ch: bad EXP/TOL/LOCK_N");
  end

  logic s1, s2, s3;
  logic tog;
  logic [CNT_W-1:0] cnt;
  blink_mon_st_e st;
  logic [PW-1:0] pass_cnt, pass_nxt;
  logic signed [CNT_W:0] diff, adiff;
  logic pass, timeout, armed;
  logic do_clr, do_arm, do_meas, do_stk;

  // Two-flop synchronizer plus one flop for edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_blink;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tog = s2 ^ s3;

  // Clocks since last toggle, saturating.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (tog) begin
      cnt <= CNT_W'(1);
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Signed distance from the expected period.
  always_comb begin
    diff  = $signed({1'b0, cnt}) - $signed(EXP_V);
    adiff = diff[CNT_W] ? -diff : diff;
  end

  assign pass    = adiff <= $signed(TOL_V);
  assign timeout = {2'b00, cnt} >= STK_V;
  assign armed   = st != IDLE;

  assign do_clr  = i_clr;
  assign do_arm  = !i_clr && tog && !armed;
  assign do_meas = !i_clr && tog && armed;
  assign do_stk  = !i_clr && !tog && armed &&
                   timeout;

  assign pass_nxt = (pass_cnt == LOCK_V) ?
                    pass_cnt : pass_cnt + 1'b1;

  // Channel FSM and registered status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st           <= IDLE;
      pass_cnt     <= '0;
      o_meas_valid <= 1'b0;
      o_period     <= '0;
      o_lock       <= 1'b0;
      o_err        <= 1'b0;
      o_stuck      <= 1'b0;
    end else begin
      o_meas_valid <= 1'b0;
      unique case (1'b1)
        do_clr: begin
          st       <= IDLE;
          pass_cnt <= '0;
          o_lock   <= 1'b0;
          o_err    <= 1'b0;
          o_stuck  <= 1'b0;
        end
        do_arm: begin
          st <= ARMED;
        end
        do_meas: begin
          st           <= MEAS;
          o_meas_valid <= 1'b1;
          o_period     <= cnt;
          if (pass) begin
            pass_cnt <= pass_nxt;
            o_lock   <= pass_nxt == LOCK_V;
          end else begin
            pass_cnt <= '0;
            o_lock   <= 1'b0;
            o_err    <= 1'b1;
          end
        end
        do_stk: begin
          st       <= IDLE;
          pass_cnt <= '0;
          o_lock   <= 1'b0;
          o_stuck  <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_blink_monitor.sv
// seq_blink_monitor: half-period checker for the
// sequential blinker, one blink_period_ch per line.
module seq_blink_monitor
  import seq_blink_pkg::*;
#(
  parameter int NUM_CH = BLINK_NUM_CH,
  parameter int CNT_W  = 16,
  parameter int EXP0   = BLINK_EXP[0],
  parameter int EXP1   = BLINK_EXP[1],
  parameter int EXP2   = BLINK_EXP[2],
  parameter int EXP3   = BLINK_EXP[3],
  parameter int EXP4   = BLINK_EXP[4],
  parameter int TOL    = 1,
  parameter int LOCK_N = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH-1:0]       i_blink,
  input  logic                    i_clr,
  output logic [NUM_CH-1:0]       o_meas_valid,
  output logic [NUM_CH*CNT_W-1:0] o_period,
  output logic [NUM_CH-1:0]       o_lock,
  output logic [NUM_CH-1:0]       o_err,
  output logic [NUM_CH-1:0]       o_stuck
);

  if (NUM_CH < 1 ||
      NUM_CH > BLINK_NUM_CH) begin : g_bad_ch
    $error("seq_blink_monitor: NUM_CH out of range");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    blink_period_ch #(
      .CNT_W (CNT_W),
      .EXP   (exp_sel(c, EXP0, EXP1, EXP2,
                      EXP3, EXP4)),
      .TOL   (TOL),
      .LOCK_N(LOCK_N)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_blink     (i_blink[c]),
      .i_clr       (i_clr),
      .o_meas_valid(o_meas_valid[c]),
      .o_period    (o_period[c*CNT_W +: CNT_W]),
      .o_lock      (o_lock[c]),
      .o_err       (o_err[c]),
      .o_stuck     (o_stuck[c])
    );
  end

endmodule

// File: tb/tb_seq_blink_monitor.sv
// tb_seq_blink_monitor: randomized blink stimulus
// against a timestamp-based reference model.
module tb_seq_blink_monitor;

  localparam int NCH   = 5;
  localparam int TOL   = 1;
  localparam int LOCKN = 3;
  localparam int EXPV [NCH] = '{50, 25, 17, 10, 5};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  blink = '0;
  logic        clr = 1'b0;
  logic [4:0]  mv, lock, err, stuck;
  logic [79:0] per;

  always #5 clk = ~clk;

  seq_blink_monitor dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_blink     (blink),
    .i_clr       (clr),
    .o_meas_valid(mv),
    .o_period    (per),
    .o_lock      (lock),
    .o_err       (err),
    .o_stuck     (stuck)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each line's sample history is kept; a toggle is
  // seen two clocks after capture, and a measurement
  // is the clock distance between seen toggles.
  int          kc = 0;
  bit          p1 [NCH], p2 [NCH], p3 [NCH];
  bit          armed [NCH];
  int          last [NCH], npass [NCH];
  logic [4:0]  m_mv = '0, m_lock = '0;
  logic [4:0]  m_err = '0, m_stuck = '0;
  logic [15:0] m_per [NCH];

  task automatic model_reset();
    m_mv = '0; m_lock = '0; m_err = '0; m_stuck = '0;
    for (int c = 0; c < NCH; c++) begin
      p1[c] = 0; p2[c] = 0; p3[c] = 0;
      armed[c] = 0; npass[c] = 0; last[c] = 0;
      m_per[c] = '0;
    end
  endtask

  task automatic model_step(input logic [4:0] b,
                            input logic cl);
    int dt, meas, d;
    bit e;
    m_mv = '0;
    for (int c = 0; c < NCH; c++) begin
      e  = p2[c] != p3[c];
      dt = kc - last[c];
      if (cl) begin
        m_err[c] = 0; m_stuck[c] = 0; m_lock[c] = 0;
        npass[c] = 0; armed[c] = 0;
        if (e) last[c] = kc;
      end else if (e) begin
        if (armed[c]) begin
          meas = (dt > 65535) ? 65535 : dt;
          m_mv[c] = 1;
          m_per[c] = 16'(meas);
          d = meas - EXPV[c];
          if (d < 0) d = -d;
          if (d <= TOL) begin
            if (npass[c] < LOCKN) npass[c]++;
            m_lock[c] = npass[c] == LOCKN;
          end else begin
            npass[c] = 0; m_lock[c] = 0; m_err[c] = 1;
          end
        end
        armed[c] = 1;
        last[c] = kc;
      end else if (armed[c] &&
                   dt >= 2 * EXPV[c] + TOL) begin
        m_stuck[c] = 1; m_lock[c] = 0;
        npass[c] = 0; armed[c] = 0;
      end
      p3[c] = p2[c];
      p2[c] = p1[c];
      p1[c] = b[c];
    end
  endtask

  // Model advance on each edge; compare 1 ns later.
  always begin
    logic [79:0] pk;
    @(posedge clk);
    kc++;
    if (rst) model_reset();
    else model_step(blink, clr);
    #1;
    for (int c = 0; c < NCH; c++)
      pk[c*16 +: 16] = m_per[c];
    chk("mv", 80'(mv), 80'(m_mv));
    chk("period", per, pk);
    chk("lock", 80'(lock), 80'(m_lock));
    chk("err", 80'(err), 80'(m_err));
    chk("stuck", 80'(stuck), 80'(m_stuck));
  end

  // ---------------- stimulus ----------------
  int per_v [NCH] = '{50, 25, 17, 10, 5};
  int left [NCH];
  bit en [NCH];
  bit tog_now [NCH];
  bit rnd_mode = 0;
  int q0 [$];

  function automatic int rnd_per(input int c);
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 2 * EXPV[c] + 2;
    if (r == 1) return 2 * EXPV[c] + TOL;
    if (r < 5)
      return EXPV[c] + int'($urandom_range(0, 4)) - 2;
    return EXPV[c];
  endfunction

  task automatic step();
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      tog_now[c] = 0;
      if (en[c]) begin
        if (left[c] <= 1) begin
          blink[c] = ~blink[c];
          tog_now[c] = 1;
          if (c == 0 && q0.size() > 0)
            left[c] = q0.pop_front();
          else if (rnd_mode)
            left[c] = rnd_per(c);
          else
            left[c] = per_v[c];
        end else begin
          left[c]--;
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_tog(input int c);
    for (int i = 0; i < 400; i++) begin
      step();
      if (tog_now[c]) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_tog%0d: got none want toggle", c);
  endtask

  task automatic restart_lines();
    blink = '0;
    for (int c = 0; c < NCH; c++) begin
      left[c] = per_v[c];
      en[c] = 1;
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) en[c] = 0;
    steps(3);
    chk("rst_outs", {mv, lock, err, stuck},
        80'(0));
    chk("rst_period", per, 80'(0));
    restart_lines();
    rst = 1'b0;

    // Nominal blinker: all lines lock.
    steps(260);
    chk("t1_period", per,
        {16'd5, 16'd10, 16'd17, 16'd25, 16'd50});
    chk("t1_lock", 80'(lock), 80'(5'h1F));
    chk("t1_err", 80'({err, stuck}), 80'(0));

    // Channel 2 off-frequency.
    per_v[2] = 20;
    steps(100);
    chk("t2_per2", 80'(per[47:32]), 80'(20));
    chk("t2_err", 80'(err), 80'(5'b00100));
    chk("t2_lock", 80'(lock), 80'(5'b11011));
    per_v[2] = 17;
    clr = 1'b1;
    step();
    clr = 1'b0;
    steps(230);

    // Channel 4 stops toggling.
    chk("t3_lock_pre", 80'(lock[4]), 80'(1));
    wait_tog(4);
    en[4] = 0;
    steps(13);
    chk("t3_stuck_early", 80'(stuck[4]), 80'(0));
    step();
    chk("t3_stuck", 80'(stuck[4]), 80'(1));
    chk("t3_lock", 80'(lock[4]), 80'(0));
    en[4] = 1;
    wait_tog(4);
    wait_tog(4);
    wait_tog(4);
    steps(3);
    chk("t3_relock_early", 80'(lock[4]), 80'(0));
    wait_tog(4);
    steps(3);
    chk("t3_relock", 80'(lock[4]), 80'(1));

    // Channel 0 tolerance edges: 49, 51 pass; 52 fails.
    wait_tog(0);
    q0.push_back(49);
    q0.push_back(51);
    q0.push_back(52);
    wait_tog(0);
    wait_tog(0);
    steps(3);
    chk("t4_p49", 80'(per[15:0]), 80'(49));
    chk("t4_e49", 80'(err[0]), 80'(0));
    wait_tog(0);
    steps(3);
    chk("t4_p51", 80'(per[15:0]), 80'(51));
    chk("t4_e51", 80'({err[0], lock[0]}), 80'(1));
    wait_tog(0);
    steps(3);
    chk("t4_p52", 80'(per[15:0]), 80'(52));
    chk("t4_e52", 80'({err[0], lock[0]}), 80'(2));
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("t4_clr_err", 80'({err, stuck}), 80'(0));
    chk("t4_hold", 80'(per[15:0]), 80'(52));

    // Clear coinciding with a channel 1 edge.
    wait_tog(1);
    wait_tog(1);
    wait_tog(1);
    steps(2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6_nopulse", 80'(mv[1]), 80'(0));
    wait_tog(1);
    steps(3);
    chk("t6_arm_only", 80'(mv[1]), 80'(0));
    wait_tog(1);
    steps(3);
    chk("t6_meas", 80'(mv[1]), 80'(1));

    // Reset mid-period.
    steps(7);
    #3 rst = 1'b1;
    #1;
    chk("t5_async", {mv, lock, err, stuck},
        80'(0));
    chk("t5_async_per", per, 80'(0));
    steps(2);
    restart_lines();
    rst = 1'b0;
    wait_tog(3);
    steps(3);
    chk("t5_first", 80'(mv[3]), 80'(0));
    wait_tog(3);
    steps(3);
    chk("t5_second", 80'(mv[3]), 80'(1));
    chk("t5_per3", 80'(per[63:48]), 80'(10));

    // Randomized jitter, stalls, clears.
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCH; c++) begin
        if (en[c] && $urandom_range(0, 499) == 0)
          en[c] = 0;
        else if (!en[c] &&
                 $urandom_range(0, 59) == 0)
          en[c] = 1;
      end
      step();
    end
    clr = 1'b0;
    steps(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
